// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// burst controller states.
package shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/shift_reg_ctrl.sv
// Burst controller: accepts start, counts down latched operations and
// produces the apply strobe, effective mode, busy and a one-cycle done.
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [2:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          apply,
  output logic [2:0]    eff_mode,
  output logic          busy,
  output logic          done
);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    lmode;

  // The start edge itself performs no operation, so start masks apply in IDLE.
  assign apply    = ce & ((state == ST_RUN) | ~start);
  assign eff_mode = (state == ST_RUN) ? lmode : mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lmode <= MODE_HOLD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ce && start) begin
            lmode <= mode;
            cnt   <= count;
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ce) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/shift_reg_univ.sv
// Universal N-bit shift register: shift, rotate, parallel load, free-run or
// counted bursts sequenced by shift_reg_ctrl.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [2:0]    mode,
  input  logic          d_r,
  input  logic          d_l,
  input  logic [N-1:0]  pd,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);
  logic         apply;
  logic [2:0]   eff_mode;
  logic [N-1:0] q_nxt;

  shift_reg_ctrl #(.CW(CW)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .mode     (mode),
    .start    (start),
    .count    (count),
    .apply    (apply),
    .eff_mode (eff_mode),
    .busy     (busy),
    .done     (done)
  );

  // Codes 110/111 fall through to hold.
  always_comb begin
    q_nxt = q;
    case (eff_mode)
      MODE_SHR:  q_nxt = {d_r, q[N-1:1]};
      MODE_SHL:  q_nxt = {q[N-2:0], d_l};
      MODE_ROR:  q_nxt = {q[0], q[N-1:1]};
      MODE_ROL:  q_nxt = {q[N-2:0], q[N-1]};
      MODE_LOAD: q_nxt = pd;
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (apply) q <= q_nxt;
  end

  assign so_r = q[0];
  assign so_l = q[N-1];
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (N=4): free-run, bursts, stalls,
// zero count and asynchronous reset, against hand-computed values.
module tb_shift_reg_univ;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, ce, d_r, d_l, start;
  logic [2:0]    mode;
  logic [N-1:0]  pd;
  logic [CW-1:0] count;
  logic [N-1:0]  q;
  logic          so_r, so_l, busy, done;

  int total = 0;
  int bad   = 0;

  shift_reg_univ #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d_r(d_r), .d_l(d_l),
    .pd(pd), .start(start), .count(count), .q(q), .so_r(so_r),
    .so_l(so_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // q/busy/done after one edge
  task automatic step(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
    tick();
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; d_r = 1'b0; d_l = 1'b0; start = 1'b0;
    mode = 3'b000; pd = '0; count = '0;
    #2;
    chk("rst.q", 32'(q), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;

    // free-run SHR
    ce = 1'b1; mode = 3'b001; d_r = 1'b1;
    step("shr1", 4'b1000, 0, 0);
    step("shr2", 4'b1100, 0, 0);
    step("shr3", 4'b1110, 0, 0);
    step("shr4", 4'b1111, 0, 0);
    ce = 1'b0; d_r = 1'b0;
    step("shr_ce0a", 4'b1111, 0, 0);
    step("shr_ce0b", 4'b1111, 0, 0);

    // LOAD then burst ROL x5
    ce = 1'b1; mode = 3'b101; pd = 4'b1011;
    step("load", 4'b1011, 0, 0);
    mode = 3'b100; count = 8'd5; start = 1'b1;
    step("rol_start", 4'b1011, 1, 0);
    start = 1'b0; mode = 3'b000;
    step("rol1", 4'b0111, 1, 0);
    step("rol2", 4'b1110, 1, 0);
    step("rol3", 4'b1101, 1, 0);
    step("rol4", 4'b1011, 1, 0);
    step("rol5", 4'b0111, 0, 1);
    chk("rol5.so_r", 32'(so_r), 32'h1);
    chk("rol5.so_l", 32'(so_l), 32'h0);
    step("rol_after", 4'b0111, 0, 0);

    // stalled SHL burst, start during RUN ignored
    mode = 3'b101; pd = 4'b0011;
    step("load2", 4'b0011, 0, 0);
    mode = 3'b010; d_l = 1'b0; count = 8'd2; start = 1'b1;
    step("shl_start", 4'b0011, 1, 0);
    start = 1'b0; mode = 3'b000;
    step("shl1", 4'b0110, 1, 0);
    ce = 1'b0;
    step("stall1", 4'b0110, 1, 0);
    start = 1'b1; mode = 3'b001;
    step("stall2", 4'b0110, 1, 0);
    start = 1'b0;
    step("stall3", 4'b0110, 1, 0);
    ce = 1'b1; start = 1'b1; mode = 3'b101; pd = 4'b1111;
    step("shl2", 4'b1100, 0, 1);
    start = 1'b0; mode = 3'b000;
    step("shl_after", 4'b1100, 0, 0);

    // zero count
    mode = 3'b001; d_r = 1'b1; count = 8'd0; start = 1'b1;
    step("zc_start", 4'b1100, 0, 1);
    start = 1'b0; mode = 3'b000;
    step("zc_after", 4'b1100, 0, 0);

    // reset mid-burst
    mode = 3'b101; pd = 4'b1001;
    step("load3", 4'b1001, 0, 0);
    mode = 3'b011; count = 8'd6; start = 1'b1;
    step("ror_start", 4'b1001, 1, 0);
    start = 1'b0; mode = 3'b000;
    step("ror1", 4'b1100, 1, 0);
    step("ror2", 4'b0110, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk("midrst.q", 32'(q), 32'h0);
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.done", 32'(done), 32'h0);
    step("rst_hold", 4'b0000, 0, 0);
    rst = 1'b0;
    step("post_rst", 4'b0000, 0, 0);
    mode = 3'b101; pd = 4'b1010; count = 8'd1; start = 1'b1;
    step("ld_start", 4'b0000, 1, 0);
    start = 1'b0; mode = 3'b000;
    step("ld1", 4'b1010, 0, 1);
    chk("ld1.so_r", 32'(so_r), 32'h0);
    chk("ld1.so_l", 32'(so_l), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
